xm23_fetch_sequencer: RTL
=========================

# xm23_fetch_sequencer

Fetch sequencer for the XM23 pipeline. It derives a clock-enable tick from `clk_in` in place of a divided clock, then drives the instruction-memory handshake. It also maintains the PC and presents the fetched instruction register to the decode stage, honouring stall and branch-redirect requests from downstream. It supports free-run, halt and single-step for bring-up on the FPGA board.

## Interface
- `DIVIDER`, default 50_000_000: `clk_in` cycles per pipeline tick; legal values are ≥ 2.
- `PC_RESET`, default 16'h0000: PC value after reset; bit 0 is forced to 0.
- `clk_in`  in  1  System clock, 50 MHz.
- `reset`  in  1  Asynchronous, active-high.
- `run`  in  1  Level input. 1 = free-run ticks; 0 = halted.
- `step`  in  1  Synchronous input. A rising edge while `run`=0 produces exactly one tick.
- `tick`  out  1  One-cycle pulse, one per pipeline step.
- `led`  out  1  Heartbeat; toggles on every tick.
- `imem_req`  out  1  Fetch request.
- `imem_addr`  out  16  Fetch byte address; equals `pc`.
- `imem_ack`  in  1  Memory acknowledge, sampled only while in FETCH.
- `imem_rdata`  in  16  Instruction word; valid when `imem_ack`=1.
- `stall`  in  1  Decode hazard: hold the instruction register this step.
- `branch_taken`  in  1  Redirect request from execute.
- `branch_target`  in  16  Redirect address.
- `pc`  out  16  Address of the next instruction to fetch.
- `ir`  out  16  Instruction register feeding decode.
- `ir_valid`  out  1  `ir` holds a live (unflushed) instruction.
- `ir_load`  out  1  One-cycle pulse: `ir` was updated on the previous edge.
- `overrun`  out  1  Sticky flag: a tick was dropped.

## Operation
- All outputs reset to 0 except `pc`, which resets to `PC_RESET & 16'hFFFE`.
- After reset the FSM is in WAIT and `counter`=0.
- **Tick generator**
  - While `run`=1, `counter` counts 0..DIVIDER-1.
  - `tick` pulses in the cycle after `counter`=DIVIDER-1, and `counter` returns to 0.
  - While `run`=0, `counter` is held at 0.
  - A `step` rising edge (registered edge detect) produces `tick` one cycle later.
  - `step` is ignored while `run`=1.
- **FSM states: WAIT and FETCH.**
- **WAIT**, when a tick is seen (either `tick`, or `pend` from a deferred tick). The three cases are checked in priority order:
  1. `stall`=1: `ir`, `ir_valid` and `pc` hold; stay in WAIT.
  2. `branch_taken`=1: `pc` ← `branch_target & 16'hFFFE`; `ir_valid` ← 0 (flush); go to FETCH.
  3. Otherwise: go to FETCH.
- **FETCH**
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`=1: `ir` ← `imem_rdata`, `ir_valid` ← 1, `pc` ← `pc`+2 (mod 2^16; 16'hFFFE wraps to 16'h0000); go to WAIT.
- **Ticks arriving during FETCH**
  - The first tick sets `pend`.
  - A tick arriving while `pend`=1 sets `overrun` (sticky until reset) and is discarded.
  - `pend` is consumed as the tick on the first WAIT cycle.
- `stall` and `branch_taken` are sampled only on an accepted tick in WAIT. Downstream holds them until then.
- `imem_ack` outside FETCH is ignored.

## Timing
- `tick` is registered.
- A tick seen in WAIT during cycle t moves the FSM to FETCH at the end of t, so `imem_req`=1 from cycle t+1.
- `imem_ack` may be high in the first FETCH cycle. With ack in cycle t+1, `ir`, `ir_valid` and `pc` update at the end of t+1, and `ir_load`=1 during t+2.
- Minimum tick-to-`ir_load` latency is therefore 2 cycles. Each ack wait cycle adds 1.
- `imem_req` deasserts in the cycle after the ack cycle.
- **Asynchronous reset mid-FETCH:** `imem_req` drops immediately. A pending ack is lost. `pend` and `overrun` clear.
- **`run` falling mid-count:** `counter` clears the next cycle and no tick is emitted. A FETCH already in progress completes.

## Test plan
Directed tests use DIVIDER=4 and PC_RESET=16'h0000, with memory returning `addr` ^ 16'h4008.

1. **Free-run sequence.** `run`=1, ack in the first FETCH cycle, no stall or branch.
   - `tick` every 4 cycles.
   - `imem_addr` sequence is 0, 2, 4, 6.
   - `ir` = 16'h4008, 16'h400A, 16'h400C, 16'h400E.
   - `ir_load` pulses 2 cycles after each tick; `led` toggles each tick.
2. **Stall.**
   - `stall`=1 across one tick → no `imem_req`; `ir` and `pc` unchanged.
   - Next tick with `stall`=0 → fetch from the held `pc`.
3. **Branch redirect.** `branch_taken`=1, `branch_target`=16'h0101 on a tick.
   - `ir_valid` drops to 0; `imem_addr`=16'h0100.
   - `ir`=16'h4108 after ack; `ir_valid`=1.
4. **Wrap-around.** Branch to 16'hFFFE, then fetch → `pc` becomes 16'h0000 after ack.
5. **Single-step and overrun.**
   - `run`=0 with three `step` edges 10 cycles apart → exactly 3 ticks and 3 fetches.
   - Then `run`=1 with ack delayed 9 cycles → `pend` is taken, one tick is dropped, and `overrun`=1 persists.
6. **Reset mid-FETCH.** Assert `reset` while `imem_req`=1 → all outputs go to their reset values immediately. After release, the first fetch is from 16'h0000.

Source files
------------

// File: rtl/xm23_fetch_sequencer.sv
// XM23 fetch sequencer: clock-enable tick generator, PC and
// instruction register, instruction-memory handshake.
module xm23_fetch_sequencer #(
    parameter int unsigned DIVIDER  = 50_000_000,
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    output logic        tick,
    output logic        led,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        ir_load,
    output logic        overrun
);

    localparam int CW = $clog2(DIVIDER);
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);
    localparam logic [15:0] PC_INIT = {PC_RESET[15:1], 1'b0};

    typedef enum logic {
        S_WAIT,
        S_FETCH
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] counter;
    logic          step_q;
    logic          tick_nxt;
    logic          pend, pend_nxt;
    logic          overrun_nxt;
    logic          valid_nxt;
    logic          load_nxt;
    logic [15:0]   pc_nxt, ir_nxt;

    // Free-run divider end-of-count, or a step edge while halted.
    assign tick_nxt = run ? (counter == LAST) : (step & ~step_q);

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;

    // Tick generator: divider counter, step edge detect, heartbeat.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            counter <= '0;
            step_q  <= 1'b0;
            tick    <= 1'b0;
            led     <= 1'b0;
        end else begin
            step_q <= step;
            tick   <= tick_nxt;
            led    <= led ^ tick_nxt;
            if (!run || counter == LAST) begin
                counter <= '0;
            end else begin
                counter <= counter + 1'b1;
            end
        end
    end

    // Sequencer state, PC, instruction register and tick bookkeeping.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state    <= S_WAIT;
            pc       <= PC_INIT;
            ir       <= '0;
            ir_valid <= 1'b0;
            ir_load  <= 1'b0;
            pend     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            ir       <= ir_nxt;
            ir_valid <= valid_nxt;
            ir_load  <= load_nxt;
            pend     <= pend_nxt;
            overrun  <= overrun_nxt;
        end
    end

    // Next-state logic: accept ticks in WAIT, complete fetches in FETCH.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        valid_nxt   = ir_valid;
        load_nxt    = 1'b0;
        pend_nxt    = pend;
        overrun_nxt = overrun;
        unique case (state)
            S_WAIT: begin
                // A deferred tick is consumed here; a fresh one
                // arriving in the same cycle cannot be kept.
                pend_nxt = 1'b0;
                if (tick && pend) begin
                    overrun_nxt = 1'b1;
                end
                if ((tick || pend) && !stall) begin
                    state_nxt = S_FETCH;
                    if (branch_taken) begin
                        pc_nxt    = {branch_target[15:1], 1'b0};
                        valid_nxt = 1'b0;
                    end
                end
            end
            S_FETCH: begin
                if (tick) begin
                    if (pend) begin
                        overrun_nxt = 1'b1;
                    end else begin
                        pend_nxt = 1'b1;
                    end
                end
                if (imem_ack) begin
                    ir_nxt    = imem_rdata;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc + 16'd2;
                    load_nxt  = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            default: begin
                state_nxt = S_WAIT;
            end
        endcase
    end

endmodule
